// File: rtl/arc4_ct_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arc4_ct_gen
//
// ARC4 encryptor that builds a length-prefixed ciphertext memory.
//
// It reads a length-prefixed plaintext (byte 0 = L, bytes 1..L = message)
// from a synchronous-read memory and writes the ciphertext through the write
// port of the memory that the cracking engines read. The length byte is
// copied unencrypted to ct[0], and ct[k] = pt[k] ^ keystream for k = 1..L.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         start request, only looked at while rdy=1
//   rdy        high = idle and able to accept en
//   key        ARC4 key, KEY_W bits; key byte n = key[KEY_W-1-8n -: 8]
//   pt_addr    plaintext read address
//   pt_rddata  plaintext read data, valid one cycle after pt_addr
//   ct_addr    ciphertext write address
//   ct_wrdata  ciphertext write data
//   ct_wren    ciphertext write strobe, one cycle per byte
//   dbg_state  current FSM state, for checkers and debug
//
// Handshake: a run starts on the rising edge where en=1 and rdy=1; key is
// captured on that same edge. rdy then stays low until the run finishes, and
// en (and key) are ignored for the whole time rdy is low. en held high is
// accepted again on the first edge where rdy is back high.
// -----------------------------------------------------------------------------
module arc4_ct_gen #(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata,
  output logic [7:0]       ct_addr,
  output logic [7:0]       ct_wrdata,
  output logic             ct_wren,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    KSA    = 3'd2,
    LEN_RD = 3'd3,
    LEN_WR = 3'd4,
    P_RD   = 3'd5,
    P_WR   = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;

  // ARC4 state and indices
  logic [7:0]       s_mem [0:255];
  logic [7:0]       i;
  logic [7:0]       j;
  logic [7:0]       len;

  // The key is held rotated so the byte for the current KSA step is always
  // the top byte; rotating once per step gives key[i mod KEY_BYTES] without
  // a modulo counter.
  logic [KEY_W-1:0] key_rot;

  // Shared swap datapath for KSA and P_RD
  logic [7:0]       swap_a;    // index being swapped with S[jn]
  logic [7:0]       sa;        // S[swap_a]
  logic [7:0]       key_term;  // key byte in KSA, zero in PRGA
  logic [7:0]       jn;        // new j
  logic [7:0]       sb;        // S[jn]

  // Keystream datapath for P_WR (uses the already-swapped S, i, j)
  logic [7:0]       s_i;
  logic [7:0]       s_j;
  logic [7:0]       t_idx;
  logic [7:0]       ks;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (en) state_nxt = INIT;
      INIT:   if (i == 8'd255) state_nxt = KSA;
      KSA:    if (i == 8'd255) state_nxt = LEN_RD;
      LEN_RD: state_nxt = LEN_WR;
      // The length is decided from the live read data; len is only being
      // captured on this same edge.
      LEN_WR: state_nxt = (pt_rddata == 8'd0) ? DONE : P_RD;
      P_RD:   state_nxt = P_WR;
      P_WR:   state_nxt = (i == len) ? DONE : P_RD;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Swap and keystream datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    swap_a   = (state == P_RD) ? (i + 8'd1) : i;
    sa       = s_mem[swap_a];
    key_term = (state == KSA) ? key_rot[KEY_W-1 -: 8] : 8'd0;
    jn       = j + sa + key_term;
    sb       = s_mem[jn];

    s_i      = s_mem[i];
    s_j      = s_mem[j];
    t_idx    = s_i + s_j;
    ks       = s_mem[t_idx];
  end

  // ---------------------------------------------------------------------------
  // Index, length and key registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i       <= 8'd0;
      j       <= 8'd0;
      len     <= 8'd0;
      key_rot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            key_rot <= key;
            i       <= 8'd0;
            j       <= 8'd0;
          end
        end
        INIT: begin
          // i wraps from 255 back to 0, ready for KSA
          i <= i + 8'd1;
        end
        KSA: begin
          i       <= swap_a;
          j       <= jn;
          key_rot <= {key_rot[KEY_W-9:0], key_rot[KEY_W-1 -: 8]};
          // swap_a == i here, so i advances on the next line's edge
          i       <= i + 8'd1;
        end
        LEN_WR: begin
          len <= pt_rddata;
          i   <= 8'd0;
          j   <= 8'd0;
        end
        P_RD: begin
          i <= swap_a;
          j <= jn;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // S register file. Contents do not need a reset; every run rebuilds it in
  // INIT. When swap_a == jn both writes carry the same value, so the swap
  // correctly leaves S unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      s_mem[i] <= i;
    end else if (state == KSA || state == P_RD) begin
      s_mem[swap_a] <= sb;
      s_mem[jn]     <= sa;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All are decoded from the state so that an asynchronous reset
  // drops ct_wren and raises rdy immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy       = (state == IDLE);
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    dbg_state = state;
    case (state)
      P_RD: begin
        // k = i + 1; read data returns in the following P_WR cycle
        pt_addr = swap_a;
      end
      LEN_WR: begin
        ct_wren   = 1'b1;
        ct_addr   = 8'd0;
        ct_wrdata = pt_rddata;
      end
      P_WR: begin
        ct_wren   = 1'b1;
        ct_addr   = i;
        ct_wrdata = pt_rddata ^ ks;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_ct_gen.sv
`timescale 1ns/1ps
module tb_arc4_ct_gen;

  localparam int W  = 16;   // {addr, data} per ciphertext write
  localparam int NV = 6;

  typedef struct {
    logic [23:0] key;
    int          len;
    int          kind;       // 0 = "Plaintext" message, 1 = random bytes
    int          exp_edges;  // edges from accept to rdy high
  } vec_t;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [23:0] key = 24'd0;
  logic        rdy;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata = 8'd0;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic [2:0]  dbg_state;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  orig   [256];
  logic [7:0]  known_ct [10];

  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cnt = 0;
  int max_pt   = 0;
  bit mon_on   = 1'b0;

  vec_t vecs [NV];

  arc4_ct_gen #(.KEY_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Plaintext ROM with synchronous read, ciphertext RAM write port
  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every ct write is popped against the expected queue
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (mon_on) begin
      if (int'(pt_addr) > max_pt) max_pt = int'(pt_addr);
      if (ct_wren) begin
        wren_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ct_write_unexpected: addr %0d data %02h, expected queue empty",
                   ct_addr, ct_wrdata);
        end else begin
          e = exp_q.pop_front();
          chk("ct_write {addr,data}", {16'd0, ct_addr, ct_wrdata}, {16'd0, e});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain software ARC4 over pt_mem, pushes expected writes
  // ---------------------------------------------------------------------------
  task automatic golden(input logic [23:0] k, output int len);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] tmp;
    int ii, jj, t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s[x]) + int'(kb[x % 3])) % 256;
      tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
    end
    len = int'(pt_mem[0]);
    exp_q.push_back({8'd0, pt_mem[0]});
    ii = 0;
    jj = 0;
    for (int x = 1; x <= len; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      t = (int'(s[ii]) + int'(s[jj])) % 256;
      exp_q.push_back({8'(x), pt_mem[x] ^ s[t]});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic load_msg(input int kind, input int len);
    string txt;
    txt = "Plaintext";
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'($urandom_range(0, 255));
    pt_mem[0] = 8'(len);
    if (kind == 0) begin
      for (int x = 0; x < 9; x++) pt_mem[x + 1] = txt[x];
    end
  endtask

  // Called at a negedge with rdy high; returns at the negedge after accept
  task automatic accept(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    key = 24'($urandom());
  endtask

  // Counts rising edges until rdy is seen high (bounded)
  task automatic wait_rdy(output int n);
    n = 0;
    while (rdy !== 1'b1 && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (n >= 3000) $display("FAIL wait_rdy_timeout: rdy still %0b after %0d edges", rdy, n);
  endtask

  task automatic do_run(input logic [23:0] k, input int exp_edges, input int tag);
    int n, len;
    golden(k, len);
    wren_cnt = 0;
    max_pt   = 0;
    accept(k);
    chk($sformatf("run%0d_rdy_busy", tag), rdy, 0);
    wait_rdy(n);
    chk($sformatf("run%0d_edges", tag), n, exp_edges);
    chk($sformatf("run%0d_wren_count", tag), wren_cnt, len + 1);
    chk($sformatf("run%0d_queue_left", tag), exp_q.size(), 0);
    chk($sformatf("run%0d_max_pt_addr", tag), max_pt, len);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n, len, mism;

    known_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    vecs[0] = '{24'h4B6579,   9, 0,  533};
    vecs[1] = '{24'h123456,   0, 1,  515};
    vecs[2] = '{24'hABCDEF,   1, 1,  517};
    vecs[3] = '{24'h000018, 255, 1, 1025};
    vecs[4] = '{24'hFFFFFF,  16, 1,  547};
    vecs[5] = '{24'h000000,   3, 1,  521};

    for (int x = 0; x < 256; x++) begin
      pt_mem[x] = 8'd0;
      ct_mem[x] = 8'd0;
    end

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rdy",       rdy,       1);
    chk("reset_ct_wren",   ct_wren,   0);
    chk("reset_pt_addr",   pt_addr,   0);
    chk("reset_ct_addr",   ct_addr,   0);
    chk("reset_ct_wrdata", ct_wrdata, 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", rdy, 1);

    // table-driven runs
    for (int v = 0; v < NV; v++) begin
      load_msg(vecs[v].kind, vecs[v].len);
      do_run(vecs[v].key, vecs[v].exp_edges, v);
      if (v == 0) begin
        for (int x = 0; x < 10; x++)
          chk($sformatf("known_ct[%0d]", x), ct_mem[x], known_ct[x]);
      end
    end

    // round trip: encrypt then decrypt with the same key
    load_msg(1, 255);
    for (int x = 0; x < 256; x++) orig[x] = pt_mem[x];
    do_run(24'h000018, 1025, 10);
    for (int x = 0; x < 256; x++) pt_mem[x] = ct_mem[x];
    do_run(24'h000018, 1025, 11);
    mism = 0;
    for (int x = 0; x < 256; x++) if (ct_mem[x] !== orig[x]) mism++;
    chk("round_trip_mismatches", mism, 0);

    // en pulse and key change while busy
    load_msg(1, 12);
    golden(24'h31C4A7, len);
    wren_cnt = 0;
    accept(24'h31C4A7);
    repeat (99) @(posedge clk);
    @(negedge clk);
    en  = 1'b1;
    key = 24'h777777;
    @(posedge clk);                          // E100
    @(negedge clk);
    en = 1'b0;
    chk("busy_en_no_restart_rdy", rdy, 0);
    wait_rdy(n);
    chk("busy_en_edges", n + 100, 515 + 2 * len);
    chk("busy_en_wren_count", wren_cnt, len + 1);
    chk("busy_en_queue_left", exp_q.size(), 0);

    // asynchronous reset abort at E300
    load_msg(1, 40);
    golden(24'hC0FFEE, len);
    wren_cnt = 0;
    accept(24'hC0FFEE);
    repeat (300) @(posedge clk);             // E300
    #2 rst_n = 1'b0;
    #1;
    chk("abort300_rdy",     rdy,     1);
    chk("abort300_ct_wren", ct_wren, 0);
    exp_q.delete();
    wren_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort300_no_writes", wren_cnt, 0);
    do_run(24'hC0FFEE, 515 + 2 * 40, 20);

    // asynchronous reset abort in the middle of the ciphertext writes
    load_msg(1, 255);
    golden(24'h5EED01, len);
    wren_cnt = 0;
    accept(24'h5EED01);
    repeat (530) @(posedge clk);             // E530
    #2 rst_n = 1'b0;
    #1;
    chk("abort530_rdy",     rdy,     1);
    chk("abort530_ct_wren", ct_wren, 0);
    chk("abort530_writes_before", wren_cnt, 9);
    exp_q.delete();
    wren_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort530_no_writes", wren_cnt, 0);
    do_run(24'h5EED01, 1025, 21);

    // back-to-back with en held high
    load_msg(1, 20);
    golden(24'h0A0B0C, len);
    wren_cnt = 0;
    @(negedge clk);
    key = 24'h0A0B0C;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key = 24'h5A5A5A;
    wait_rdy(n);
    chk("b2b_first_edges", n, 515 + 2 * len);
    chk("b2b_first_wren_count", wren_cnt, len + 1);
    chk("b2b_first_queue_left", exp_q.size(), 0);
    golden(24'h5A5A5A, len);
    wren_cnt = 0;
    @(posedge clk);                          // re-accept edge
    @(negedge clk);
    en = 1'b0;
    chk("b2b_reaccept", rdy, 0);
    wait_rdy(n);
    chk("b2b_second_edges", n, 515 + 2 * len);
    chk("b2b_second_wren_count", wren_cnt, len + 1);
    chk("b2b_second_queue_left", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #3000000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
